whack_a_mole_scorer: RTL and testbench

WHACK_A_MOLE_SCORER -- requirements
Module: whack_a_mole_scorer

---
 rtl/whack_a_mole_scorer.sv | 187 ++++++++++++++++++
 tb/tb_whack_a_mole_scorer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/whack_a_mole_scorer.sv
// rtl/whack_a_mole_scorer.sv - whack-a-mole hit/miss scoring with BCD score, high score and feedback flashes
module whack_a_mole_scorer #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int FLASH_MS     = 200,
    parameter int STREAK_BONUS = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        game_in_progress,
    input  logic        mole_clk,
    input  logic        whack_button_pressed,
    output logic [11:0] score_bcd,
    output logic [11:0] high_score_bcd,
    output logic [7:0]  misses,
    output logic [7:0]  streak,
    output logic        hit_flash,
    output logic        miss_flash
);

    localparam int TICK_DIV = (CLK_FREQ_HZ / 1000 > 1) ? CLK_FREQ_HZ / 1000 : 1;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FLASH_W  = (FLASH_MS > 0) ? $clog2(FLASH_MS + 1) : 1;
    localparam int BONUS_AT = STREAK_BONUS - 1;

    typedef enum logic [1:0] {IDLE, DOWN, UP, HIT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                sync1;
    logic                sync2;
    logic                sync2_d;
    logic                whack;
    logic [TICK_W-1:0]   tick_cnt;
    logic                ms_tick;
    logic [FLASH_W-1:0]  flash_cnt;
    logic                game_start;
    logic                game_end;
    logic                hit_evt;
    logic                miss_evt;
    logic                bonus;

    // Per-digit BCD add that pins at 999 instead of wrapping.
    function automatic logic [11:0] bcd_add(input logic [11:0] v, input logic [1:0] inc);
        logic [4:0] u;
        logic [4:0] t;
        logic [4:0] h;
        u = {1'b0, v[3:0]} + {3'b000, inc};
        t = {1'b0, v[7:4]};
        h = {1'b0, v[11:8]};
        if (u > 5'd9) begin
            u = u - 5'd10;
            t = t + 5'd1;
        end
        if (t > 5'd9) begin
            t = t - 5'd10;
            h = h + 5'd1;
        end
        if (h > 5'd9) begin
            return 12'h999;
        end
        return {h[3:0], t[3:0], u[3:0]};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= whack_button_pressed;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign whack = sync2 & ~sync2_d;

    assign ms_tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (ms_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (game_in_progress) state_nxt = mole_clk ? UP : DOWN;
            DOWN: begin
                if (!game_in_progress)        state_nxt = IDLE;
                else if (whack && mole_clk)   state_nxt = HIT;
                else if (!whack && mole_clk)  state_nxt = UP;
            end
            UP: begin
                if (!game_in_progress)        state_nxt = IDLE;
                else if (whack)               state_nxt = HIT;
                else if (!mole_clk)           state_nxt = DOWN;
            end
            HIT: begin
                if (!game_in_progress)        state_nxt = IDLE;
                else if (!mole_clk)           state_nxt = DOWN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Leaving the game wins over any whack or mole change in the same cycle.
    always_comb begin
        game_start = 1'b0;
        game_end   = 1'b0;
        hit_evt    = 1'b0;
        miss_evt   = 1'b0;
        if (state == IDLE) begin
            game_start = game_in_progress;
        end else if (!game_in_progress) begin
            game_end = 1'b1;
        end else begin
            hit_evt  = whack && ((state == UP) || (state == DOWN && mole_clk));
            miss_evt = (state == DOWN && whack && !mole_clk) ||
                       (state == UP && !whack && !mole_clk);
        end
    end

    assign bonus = (int'(streak) >= BONUS_AT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_bcd      <= '0;
            high_score_bcd <= '0;
            misses         <= '0;
            streak         <= '0;
        end else begin
            if (game_start) begin
                score_bcd <= '0;
                misses    <= '0;
                streak    <= '0;
            end else if (hit_evt) begin
                score_bcd <= bcd_add(score_bcd, bonus ? 2'd2 : 2'd1);
                streak    <= (streak == 8'hFF) ? streak : streak + 8'd1;
            end else if (miss_evt) begin
                misses    <= (misses == 8'hFF) ? misses : misses + 8'd1;
                streak    <= '0;
            end
            if (game_end && (score_bcd > high_score_bcd)) begin
                high_score_bcd <= score_bcd;
            end
        end
    end

    // The counter runs to zero and the flag drops on the following tick, giving FLASH_MS..FLASH_MS+1 ms.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_flash  <= 1'b0;
            miss_flash <= 1'b0;
            flash_cnt  <= '0;
        end else if (hit_evt) begin
            hit_flash  <= 1'b1;
            miss_flash <= 1'b0;
            flash_cnt  <= FLASH_W'(FLASH_MS);
        end else if (miss_evt) begin
            hit_flash  <= 1'b0;
            miss_flash <= 1'b1;
            flash_cnt  <= FLASH_W'(FLASH_MS);
        end else if (ms_tick && (hit_flash || miss_flash)) begin
            if (flash_cnt == '0) begin
                hit_flash  <= 1'b0;
                miss_flash <= 1'b0;
            end else begin
                flash_cnt <= flash_cnt - FLASH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_whack_a_mole_scorer.sv
// tb/tb_whack_a_mole_scorer.sv - directed and random stimulus against a behavioural scoring model
module tb_whack_a_mole_scorer;

    localparam int CLK_HZ = 10_000;
    localparam int DIV    = CLK_HZ / 1000;
    localparam int FMS    = 4;
    localparam int BONUS  = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        gip = 1'b0;
    logic        mole = 1'b0;
    logic        btn = 1'b0;
    logic [11:0] score_bcd;
    logic [11:0] high_score_bcd;
    logic [7:0]  misses;
    logic [7:0]  streak;
    logic        hit_flash;
    logic        miss_flash;

    int total = 0;
    int bad = 0;

    whack_a_mole_scorer #(
        .CLK_FREQ_HZ (CLK_HZ),
        .FLASH_MS    (FMS),
        .STREAK_BONUS(BONUS)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .game_in_progress    (gip),
        .mole_clk            (mole),
        .whack_button_pressed(btn),
        .score_bcd           (score_bcd),
        .high_score_bcd      (high_score_bcd),
        .misses              (misses),
        .streak              (streak),
        .hit_flash           (hit_flash),
        .miss_flash          (miss_flash)
    );

    always #5 clk = ~clk;

    // Reference model: decimal integers, a "mole window already whacked" flag and a raw-button history.
    bit m_in_game, m_mole_seen, m_got_hit, h1, h2, h3, m_hf, m_mf;
    int m_score, m_high, m_miss, m_streak, m_edges, m_left;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_in_game = 0; m_mole_seen = 0; m_got_hit = 0;
        h1 = 0; h2 = 0; h3 = 0; m_hf = 0; m_mf = 0;
        m_score = 0; m_high = 0; m_miss = 0; m_streak = 0; m_edges = 0; m_left = 0;
    endtask

    task automatic model_edge();
        bit w, hit, miss;
        w = h2 && !h3;
        h3 = h2; h2 = h1; h1 = btn;
        m_edges++;
        hit = 0; miss = 0;
        if (!m_in_game) begin
            if (gip) begin
                m_in_game = 1; m_score = 0; m_miss = 0; m_streak = 0;
                m_mole_seen = mole; m_got_hit = 0;
            end
        end else if (!gip) begin
            m_in_game = 0;
            if (m_score > m_high) m_high = m_score;
        end else if (m_got_hit) begin
            if (!mole) begin m_got_hit = 0; m_mole_seen = 0; end
        end else if (w) begin
            if (m_mole_seen || mole) hit = 1; else miss = 1;
        end else if (m_mole_seen && !mole) begin
            miss = 1; m_mole_seen = 0;
        end else if (mole) begin
            m_mole_seen = 1;
        end
        if (hit) begin
            m_score = m_score + ((m_streak >= BONUS - 1) ? 2 : 1);
            if (m_score > 999) m_score = 999;
            if (m_streak < 255) m_streak++;
            m_got_hit = 1;
            m_hf = 1; m_mf = 0; m_left = FMS + 1;
        end else if (miss) begin
            if (m_miss < 255) m_miss++;
            m_streak = 0;
            m_hf = 0; m_mf = 1; m_left = FMS + 1;
        end else if ((m_edges % DIV) == 0 && m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_hf = 0; m_mf = 0; end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("score", {20'd0, score_bcd}, {20'd0, to_bcd(m_score)});
        chk("high", {20'd0, high_score_bcd}, {20'd0, to_bcd(m_high)});
        chk("misses", {24'd0, misses}, 32'(m_miss));
        chk("streak", {24'd0, streak}, 32'(m_streak));
        chk("hit_flash", {31'd0, hit_flash}, {31'd0, m_hf});
        chk("miss_flash", {31'd0, miss_flash}, {31'd0, m_mf});
    endtask

    task automatic cyc(input bit g, input bit m, input bit b);
        gip = g; mole = m; btn = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Starts and ends in the mole-down state of a running game.
    task automatic hit_once();
        cyc(1, 1, 0);
        cyc(1, 1, 1);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_score"}, {20'd0, score_bcd}, 32'd0);
        chk({tag, "_high"}, {20'd0, high_score_bcd}, 32'd0);
        chk({tag, "_misses"}, {24'd0, misses}, 32'd0);
        chk({tag, "_streak"}, {24'd0, streak}, 32'd0);
        chk({tag, "_hflash"}, {31'd0, hit_flash}, 32'd0);
        chk({tag, "_mflash"}, {31'd0, miss_flash}, 32'd0);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        // Game 1: first hit, repeated whacks in one window, escape, whack on empty hole.
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 1);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        chk("first_hit_score", {20'd0, score_bcd}, 32'h001);
        chk("first_hit_streak", {24'd0, streak}, 32'd1);
        chk("first_hit_flash", {31'd0, hit_flash}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            cyc(1, 1, 1);
            cyc(1, 1, 0);
            cyc(1, 1, 0);
            cyc(1, 1, 0);
        end
        chk("rewhack_score", {20'd0, score_bcd}, 32'h001);
        chk("rewhack_misses", {24'd0, misses}, 32'd0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        chk("escape_misses", {24'd0, misses}, 32'd1);
        chk("escape_streak", {24'd0, streak}, 32'd0);
        chk("escape_mflash", {31'd0, miss_flash}, 32'd1);
        hit_once();
        cyc(1, 0, 1);
        cyc(1, 0, 0);
        chk("pre_miss_hflash", {31'd0, hit_flash}, 32'd1);
        cyc(1, 0, 0);
        chk("empty_whack_misses", {24'd0, misses}, 32'd2);
        chk("empty_whack_hflash", {31'd0, hit_flash}, 32'd0);
        chk("empty_whack_mflash", {31'd0, miss_flash}, 32'd1);
        cyc(0, 0, 0);
        chk("game1_high", {20'd0, high_score_bcd}, 32'h002);

        // Game 2: streak bonus, then drive the score up to saturation.
        cyc(1, 0, 0);
        for (int k = 0; k < 5; k++) hit_once();
        chk("five_hits_score", {20'd0, score_bcd}, 32'h006);
        for (int k = 0; k < 496; k++) hit_once();
        chk("score_998", {20'd0, score_bcd}, 32'h998);
        hit_once();
        chk("score_sat", {20'd0, score_bcd}, 32'h999);
        chk("streak_sat", {24'd0, streak}, 32'd255);
        cyc(1, 1, 0);
        cyc(1, 1, 1);
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        chk("end_whack_score", {20'd0, score_bcd}, 32'h999);
        chk("end_whack_high", {20'd0, high_score_bcd}, 32'h999);

        // Game 3: lower score keeps the high score; flash length measured into idle.
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 1);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        n = 0;
        while (hit_flash && n < 200) begin
            cyc(0, 0, 0);
            n++;
        end
        total++;
        assert (n >= FMS * DIV && n <= (FMS + 1) * DIV) else begin
            bad++;
            $error("FAIL flash_len observed=%0d expected=%0d..%0d", n, FMS * DIV, (FMS + 1) * DIV);
        end
        chk("game3_high", {20'd0, high_score_bcd}, 32'h999);
        chk("game3_score", {20'd0, score_bcd}, 32'h001);

        // Asynchronous reset in the middle of a flash.
        cyc(1, 0, 0);
        hit_once();
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Random play against the model.
        for (int k = 0; k < 3000; k++) begin
            bit g, m, b;
            g = ($urandom_range(0, 99) < 97);
            m = ($urandom_range(0, 99) < 15) ? !mole : mole;
            b = ($urandom_range(0, 99) < 30);
            cyc(g, m, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
